dl_tdl_duc_gain: RTL and testbench

//  Downlink per-antenna digital gain stage. Sits between the DL baseband/TDM interface and the DUC.

---
 rtl/dl_tdl_duc_gain_pkg.sv | 58 +++++
 rtl/dl_tdl_duc_gain_if.sv | 21 ++
 rtl/dl_tdl_duc_gain_lut.sv | 33 +++
 rtl/dl_tdl_duc_gain.sv | 177 +++++++++++++++++
 tb/tb_dl_tdl_duc_gain.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dl_tdl_duc_gain_pkg.sv
// Shared constants, types and helpers for the DL TDL DUC gain stage.
package dl_tdl_duc_gain_pkg;

  localparam int GAIN_FRAC  = 14;
  localparam int GAIN_W     = 17;
  localparam int IDX_W      = 8;
  localparam int DATA_W     = 16;
  localparam int LUT_DEPTH  = 1 << IDX_W;
  localparam int NANT       = 4;
  localparam int BYPASS_BIT = 4;

  // Post-gain shift selection held in i_gain_ctrl[1:0].
  typedef enum logic [1:0] {
    SHIFT_X1 = 2'd0,
    SHIFT_X2 = 2'd1,
    SHIFT_X4 = 2'd2,
    SHIFT_X8 = 2'd3
  } shift_e;

  typedef struct packed {
    logic              clip;
    logic [DATA_W-1:0] y;
  } sat_t;

  // 0.25 dB attenuation steps, Q3.14 unsigned. Evaluated at elaboration only.
  function automatic logic [GAIN_W-1:0] gain_of(input int idx);
    real v;
    v = 16384.0 * (10.0 ** (-real'(idx) / 80.0));
    return GAIN_W'($rtoi(v + 0.5));
  endfunction

  // Round half-up then drop the Q3.14 fraction, keeping s bits of extra gain.
  function automatic logic signed [33:0] round_shift(input logic signed [32:0] p,
                                                     input shift_e            s);
    logic [4:0]         sh;
    logic signed [33:0] pe;
    sh = 5'(GAIN_FRAC) - 5'(s);
    pe = 34'(p);
    return (pe + (34'sd1 <<< (sh - 5'd1))) >>> sh;
  endfunction

  // Clamp to the 16-bit signed range and flag when clamping happened.
  function automatic sat_t sat16(input logic signed [33:0] v);
    sat_t r;
    if (v > 34'sd32767) begin
      r.clip = 1'b1;
      r.y    = 16'h7FFF;
    end else if (v < -34'sd32768) begin
      r.clip = 1'b1;
      r.y    = 16'h8000;
    end else begin
      r.clip = 1'b0;
      r.y    = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dl_tdl_duc_gain_if.sv
// TDM IQ sample bus into and out of the DL gain stage.
interface dl_tdl_duc_gain_if;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        i_fram_hd;
  logic        i_ant8_sel;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_fram_hd;
  logic        o_ant8_sel;

  modport master (
    output i_data, i_data_valid, i_fram_hd, i_ant8_sel,
    input  o_data, o_data_valid, o_fram_hd, o_ant8_sel
  );

  modport slave (
    input  i_data, i_data_valid, i_fram_hd, i_ant8_sel,
    output o_data, o_data_valid, o_fram_hd, o_ant8_sel
  );
endinterface

// File: rtl/dl_tdl_duc_gain_lut.sv
// dB-index to linear gain ROM, 256 x 17, two registered read stages.
module dl_gain_lut
  import dl_tdl_duc_gain_pkg::*;
(
  input  logic              clk_245,
  input  logic              asy_rst,
  input  logic [IDX_W-1:0]  addr_i,
  output logic [GAIN_W-1:0] gain_o
);

  logic [GAIN_W-1:0] rom [LUT_DEPTH];
  logic [GAIN_W-1:0] rd_q;
  logic [GAIN_W-1:0] gain_q;

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam logic [GAIN_W-1:0] ENTRY = gain_of(g);
    assign rom[g] = ENTRY;
  end

  // Array read then output register: gain is valid two cycles after addr_i.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      rd_q   <= '0;
      gain_q <= '0;
    end else begin
      rd_q   <= rom[addr_i];
      gain_q <= rd_q;
    end
  end

  assign gain_o = gain_q;

endmodule

// File: rtl/dl_tdl_duc_gain.sv
// DL per-antenna digital gain: slot tagging, frame-shadowed gain indices,
// multiply / round / saturate pipeline and clip counter. Fixed latency LAT (>= 8).
module dl_tdl_duc_gain
  import dl_tdl_duc_gain_pkg::*;
#(
  parameter int XNUM = 4,
  parameter int LAT  = 8
) (
  input  logic                    clk_245,
  input  logic                    asy_rst,
  dl_tdl_duc_gain_if.slave        bus,
  input  logic [IDX_W-1:0]        i_a0_gain_idx,
  input  logic [IDX_W-1:0]        i_a1_gain_idx,
  input  logic [IDX_W-1:0]        i_a2_gain_idx,
  input  logic [IDX_W-1:0]        i_a3_gain_idx,
  input  logic [31:0]             i_gain_ctrl,
  input  logic                    i_sat_clr,
  output logic [15:0]             o_sat_cnt
);

  localparam int SLOT_W = 2;
  localparam int DS     = 6;  // stage holding the saturated / bypassed result

  // ---------------- slot tagging and gain shadowing ----------------
  logic [SLOT_W-1:0]           slot_q, slot_d, tag;
  logic [NANT-1:0][IDX_W-1:0]  act_q, act_d, act_eff, idx_in;
  logic [IDX_W-1:0]            idx_d, idx_q;

  assign idx_in = {i_a3_gain_idx, i_a2_gain_idx, i_a1_gain_idx, i_a0_gain_idx};

  // Frame header tags slot 0 and loads shadows so that same sample sees new gains.
  always_comb begin
    slot_d = slot_q;
    tag    = slot_q;
    act_d  = act_q;
    if (bus.i_fram_hd) begin
      tag    = '0;
      act_d  = idx_in;
      slot_d = (XNUM == 1) ? '0 : SLOT_W'(1);
    end else if (bus.i_data_valid) begin
      slot_d = (slot_q == SLOT_W'(XNUM - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Slots beyond the configured antenna count run at 0 dB.
  for (genvar k = 0; k < NANT; k++) begin : g_act
    if (k < XNUM) begin : g_on
      assign act_eff[k] = act_d[k];
    end else begin : g_off
      assign act_eff[k] = '0;
    end
  end

  assign idx_d = act_eff[tag];

  // Slot counter, active gain indices and the per-sample LUT address.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      slot_q <= '0;
      act_q  <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      act_q  <= act_d;
      idx_q  <= idx_d;
    end
  end

  // ---------------- sideband and raw data delay lines ----------------
  logic [LAT:1]       vld_pipe_q, fhd_pipe_q, a8_pipe_q;
  logic [5:1][31:0]   dat_pipe_q;
  logic [4:1][1:0]    s_pipe_q;
  logic [5:1]         byp_pipe_q;
  logic               unused_ctrl;

  assign unused_ctrl = ^{i_gain_ctrl[31:5], i_gain_ctrl[3:2]};

  // Control bits travel with their sample so a change only hits later samples.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      vld_pipe_q <= '0;
      fhd_pipe_q <= '0;
      a8_pipe_q  <= '0;
      dat_pipe_q <= '0;
      s_pipe_q   <= '0;
      byp_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[LAT-1:1], bus.i_data_valid};
      fhd_pipe_q <= {fhd_pipe_q[LAT-1:1], bus.i_fram_hd};
      a8_pipe_q  <= {a8_pipe_q[LAT-1:1],  bus.i_ant8_sel};
      dat_pipe_q <= {dat_pipe_q[4:1], bus.i_data};
      s_pipe_q   <= {s_pipe_q[3:1], i_gain_ctrl[1:0]};
      byp_pipe_q <= {byp_pipe_q[4:1], i_gain_ctrl[BYPASS_BIT]};
    end
  end

  // ---------------- gain lookup (stage 1 -> stage 3) ----------------
  logic [GAIN_W-1:0] gain_w;

  dl_gain_lut u_lut (
    .clk_245 (clk_245),
    .asy_rst (asy_rst),
    .addr_i  (idx_q),
    .gain_o  (gain_w)
  );

  // ---------------- multiply / round / saturate ----------------
  logic signed [DATA_W-1:0] xi3, xq3;
  logic signed [17:0]       g3;
  logic signed [32:0]       prod_i_q, prod_q_q;
  logic signed [33:0]       rnd_i_q, rnd_q_q;
  sat_t                     sat_i, sat_q;
  logic [31:0]              res6;
  logic                     clip6;

  assign xi3 = dat_pipe_q[3][31:16];
  assign xq3 = dat_pipe_q[3][15:0];
  assign g3  = {1'b0, gain_w};

  // Stage 4 product, stage 5 rounded/shifted value.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      prod_i_q <= '0;
      prod_q_q <= '0;
      rnd_i_q  <= '0;
      rnd_q_q  <= '0;
    end else begin
      prod_i_q <= 33'(xi3) * 33'(g3);
      prod_q_q <= 33'(xq3) * 33'(g3);
      rnd_i_q  <= round_shift(prod_i_q, shift_e'(s_pipe_q[4]));
      rnd_q_q  <= round_shift(prod_q_q, shift_e'(s_pipe_q[4]));
    end
  end

  // Clamp each component; bypass substitutes the untouched input word.
  always_comb begin
    sat_i = sat16(rnd_i_q);
    sat_q = sat16(rnd_q_q);
    res6  = byp_pipe_q[5] ? dat_pipe_q[5] : {sat_i.y, sat_q.y};
    clip6 = vld_pipe_q[5] & ~byp_pipe_q[5] & (sat_i.clip | sat_q.clip);
  end

  // ---------------- output tail and clip counter ----------------
  logic [LAT:DS][31:0] res_pipe_q;
  logic [LAT-1:DS]     clip_pipe_q;
  logic [15:0]         sat_cnt_q;

  // Pad the result to the fixed latency; clip flag stops one short so the
  // count changes on the same edge the sample reaches o_data.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      res_pipe_q  <= '0;
      clip_pipe_q <= '0;
    end else begin
      res_pipe_q  <= {res_pipe_q[LAT-1:DS], res6};
      clip_pipe_q <= {clip_pipe_q[LAT-2:DS], clip6};
    end
  end

  // Saturating clip counter; clear wins over a coincident increment.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      sat_cnt_q <= '0;
    end else if (i_sat_clr) begin
      sat_cnt_q <= '0;
    end else if (clip_pipe_q[LAT-1] && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign bus.o_data       = res_pipe_q[LAT];
  assign bus.o_data_valid = vld_pipe_q[LAT];
  assign bus.o_fram_hd    = fhd_pipe_q[LAT];
  assign bus.o_ant8_sel   = a8_pipe_q[LAT];
  assign o_sat_cnt        = sat_cnt_q;

endmodule

// File: tb/tb_dl_tdl_duc_gain.sv
// Scoreboard bench for dl_tdl_duc_gain: directed vectors, expected words pushed
// at issue time, popped and compared by a monitor whenever o_data_valid is high.
module tb_dl_tdl_duc_gain;
  import dl_tdl_duc_gain_pkg::*;

  localparam int LAT = 8;

  typedef struct {
    logic [31:0] d;
    logic        fhd;
    logic        a8;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             asy_rst = 1'b1;
  logic [3:0][7:0]  gidx, gidx_v;
  logic [31:0]      ctrl, ctrl_v;
  logic             clr, clr_v;
  logic [15:0]      sat_cnt;
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [31:0]      tagexp [4];

  dl_tdl_duc_gain_if bus_if ();

  dl_tdl_duc_gain #(.XNUM(4), .LAT(LAT)) dut (
    .clk_245       (clk),
    .asy_rst       (asy_rst),
    .bus           (bus_if),
    .i_a0_gain_idx (gidx[0]),
    .i_a1_gain_idx (gidx[1]),
    .i_a2_gain_idx (gidx[2]),
    .i_a3_gain_idx (gidx[3]),
    .i_gain_ctrl   (ctrl),
    .i_sat_clr     (clr),
    .o_sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic fhd, input logic a8,
                       input logic [31:0] e);
    exp_t x;
    @(posedge clk); #1;
    bus_if.i_data       = d;
    bus_if.i_data_valid = 1'b1;
    bus_if.i_fram_hd    = fhd;
    bus_if.i_ant8_sel   = a8;
    gidx = gidx_v;
    ctrl = ctrl_v;
    clr  = clr_v;
    x.d = e; x.fhd = fhd; x.a8 = a8; x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus_if.i_data       = 32'hA5A5_5A5A;
      bus_if.i_data_valid = 1'b0;
      bus_if.i_fram_hd    = 1'b0;
      bus_if.i_ant8_sel   = 1'b0;
      gidx = gidx_v;
      ctrl = ctrl_v;
      clr  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_o_data"},   bus_if.o_data, 32'd0);
    chk({tag, "_o_valid"},  {31'd0, bus_if.o_data_valid}, 32'd0);
    chk({tag, "_o_fram"},   {31'd0, bus_if.o_fram_hd}, 32'd0);
    chk({tag, "_o_ant8"},   {31'd0, bus_if.o_ant8_sel}, 32'd0);
    chk({tag, "_sat_cnt"},  {16'd0, sat_cnt}, 32'd0);
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!asy_rst && bus_if.o_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected no valid output", bus_if.o_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data",    bus_if.o_data, mon_e.d);
        chk("fram_hd", {31'd0, bus_if.o_fram_hd}, {31'd0, mon_e.fhd});
        chk("ant8",    {31'd0, bus_if.o_ant8_sel}, {31'd0, mon_e.a8});
        chk("latency", 32'(cyc - mon_e.cyc), 32'(LAT));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus_if.i_data = '0; bus_if.i_data_valid = 1'b0;
    bus_if.i_fram_hd = 1'b0; bus_if.i_ant8_sel = 1'b0;
    gidx_v = '0; gidx = '0; ctrl_v = '0; ctrl = '0; clr_v = 1'b0; clr = 1'b0;
    tagexp[0] = 32'h4000_0000; tagexp[1] = 32'h2013_0000;
    tagexp[2] = 32'h1013_0000; tagexp[3] = 32'h080F_0000;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk); asy_rst = 1'b0;

    // 1: unity gain ramp
    for (int n = 1; n <= 12; n++)
      drive({16'(n), 16'(n)}, (n % 4) == 1, n[0], {16'(n), 16'(n)});
    drain();
    chk("t1_sat_cnt", {16'd0, sat_cnt}, 32'd0);

    // 2: ant1 at -6 dB
    gidx_v[1] = 8'd24;
    for (int k = 0; k < 8; k++)
      drive(32'h4000_C000, (k % 4) == 0, 1'b0,
            ((k % 4) == 1) ? 32'h2013_DFED : 32'h4000_C000);
    drain();

    // 3: a0 change between headers takes effect at the next header only
    for (int k = 0; k < 12; k++) begin
      if (k == 1) gidx_v[0] = 8'd24;
      drive(32'h4000_C000, (k == 0) || (k == 8), 1'b0,
            (((k % 4) == 1) || ((k % 4) == 0 && k >= 8)) ? 32'h2013_DFED : 32'h4000_C000);
    end
    drain();

    // 4: x4 shift saturates both rails
    chk("t4_sat_pre", {16'd0, sat_cnt}, 32'd0);
    gidx_v = '0; ctrl_v = 32'h2;
    for (int k = 0; k < 5; k++)
      drive(32'h4000_8000, k == 0, 1'b0, 32'h7FFF_8000);
    drain();
    chk("t4_sat_cnt5", {16'd0, sat_cnt}, 32'd5);
    for (int k = 0; k < 12; k++) begin
      clr_v = (k == 10);
      drive(32'h4000_8000, (k % 4) == 0, 1'b0, 32'h7FFF_8000);
      if (k == 11) chk("t4_sat_clr_prio", {16'd0, sat_cnt}, 32'd0);
    end
    clr_v = 1'b0;
    drain();
    chk("t4_sat_after_clr", {16'd0, sat_cnt}, 32'd8);

    // 5: gaps, header every 7 samples, per-slot gains expose the tags
    ctrl_v = '0;
    gidx_v[0] = 8'd0; gidx_v[1] = 8'd24; gidx_v[2] = 8'd48; gidx_v[3] = 8'd72;
    for (int j = 0; j < 18; j++) begin
      drive(32'h4000_0000, (j % 7) == 0, j[0], tagexp[(j % 7) % 4]);
      idle(1 + (j % 2));
    end
    drive(32'h4000_0000, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #2;
    asy_rst = 1'b1;
    bus_if.i_data_valid = 1'b0;
    bus_if.i_fram_hd = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    asy_rst = 1'b0;

    // Recovery: active gains were cleared, no header seen yet -> unity
    idle(3);
    for (int n = 1; n <= 8; n++)
      drive({16'(n * 3), 16'(n)}, 1'b0, n[0], {16'(n * 3), 16'(n)});
    drain();
    chk("recov_sat_cnt", {16'd0, sat_cnt}, 32'd0);

    // 6: bypass with s=3, then bypass dropped on the very next sample
    ctrl_v = 32'h13;
    drive(32'h4000_8000, 1'b0, 1'b0, 32'h4000_8000);
    drive(32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF);
    drive(32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678);
    ctrl_v = 32'h0;
    drive(32'h0005_0006, 1'b0, 1'b1, 32'h0005_0006);
    drain();
    chk("t6_sat_cnt", {16'd0, sat_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
